// File: rtl/cfu_cmd_initiator_if.sv
// Bundle of the host request, CFU command/response and result streams.
// master = initiator side, slave = host + CFU side.
interface cfu_cmd_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_function_id;
  logic [31:0] req_in0;
  logic [31:0] req_in1;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_err;

  modport master (
    input  req_valid, req_function_id, req_in0, req_in1,
    output req_ready,
    output cmd_valid, cmd_payload_function_id,
    output cmd_payload_inputs_0, cmd_payload_inputs_1,
    input  cmd_ready,
    input  rsp_valid, rsp_payload_outputs_0,
    output rsp_ready,
    output res_valid, res_data, res_err,
    input  res_ready
  );

  modport slave (
    output req_valid, req_function_id, req_in0, req_in1,
    input  req_ready,
    input  cmd_valid, cmd_payload_function_id,
    input  cmd_payload_inputs_0, cmd_payload_inputs_1,
    output cmd_ready,
    output rsp_valid, rsp_payload_outputs_0,
    input  rsp_ready,
    input  res_valid, res_data, res_err,
    output res_ready
  );
endinterface

// File: rtl/cfu_cmd_initiator.sv
// CFU command initiator: request FIFO plus a one-outstanding
// issue/wait/return FSM with response timeout.
module cfu_cmd_initiator #(
  parameter int          DEPTH    = 4,
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  cfu_cmd_initiator_if.master  bus,
  output logic                 busy,
  output logic [15:0]          done_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int EW = 74;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          avail_q;
  logic          full;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  logic          cmd_valid_q, cmd_valid_d;
  logic [9:0]    fid_q, fid_d;
  logic [31:0]   in0_q, in0_d;
  logic [31:0]   in1_q, in1_d;
  logic          rsp_ready_q, rsp_ready_d;
  logic          res_valid_q, res_valid_d;
  logic [31:0]   res_data_q, res_data_d;
  logic          res_err_q, res_err_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   done_q, done_d;

  assign full = (count_q == CW'(DEPTH));
  assign push = bus.req_valid && !full;
  assign head = mem_q[rd_ptr_q];

  // FIFO storage, pointers, occupancy; avail_q lags the count by
  // one cycle so a fresh entry spends one cycle in the FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      avail_q  <= 1'b0;
    end else begin
      avail_q <= (count_q != '0);
      if (push) begin
        mem_q[wr_ptr_q] <= {bus.req_function_id, bus.req_in0,
                            bus.req_in1};
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Next state and next register values for the job FSM.
  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    fid_d       = fid_q;
    in0_d       = in0_q;
    in1_d       = in1_q;
    rsp_ready_d = rsp_ready_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    timer_d     = timer_q;
    done_d      = done_q;
    pop         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (avail_q && count_q != '0) begin
          pop         = 1'b1;
          fid_d       = head[73:64];
          in0_d       = head[63:32];
          in1_d       = head[31:0];
          cmd_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_valid_q && bus.cmd_ready) begin
          cmd_valid_d = 1'b0;
          rsp_ready_d = 1'b1;
          timer_d     = '0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        timer_d = timer_q + TW'(1);
        if (bus.rsp_valid) begin
          res_data_d  = bus.rsp_payload_outputs_0;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          rsp_ready_d = 1'b0;
          state_d     = DONE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          res_data_d  = ERR_DATA;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          rsp_ready_d = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (res_valid_q && bus.res_ready) begin
          res_valid_d = 1'b0;
          res_err_d   = 1'b0;
          done_d      = done_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cmd_valid_q <= 1'b0;
      fid_q       <= '0;
      in0_q       <= '0;
      in1_q       <= '0;
      rsp_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      timer_q     <= '0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      fid_q       <= fid_d;
      in0_q       <= in0_d;
      in1_q       <= in1_d;
      rsp_ready_q <= rsp_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      timer_q     <= timer_d;
      done_q      <= done_d;
    end
  end

  assign bus.req_ready               = !full;
  assign bus.cmd_valid               = cmd_valid_q;
  assign bus.cmd_payload_function_id = fid_q;
  assign bus.cmd_payload_inputs_0    = in0_q;
  assign bus.cmd_payload_inputs_1    = in1_q;
  assign bus.rsp_ready               = rsp_ready_q;
  assign bus.res_valid               = res_valid_q;
  assign bus.res_data                = res_data_q;
  assign bus.res_err                 = res_err_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign done_count = done_q;

endmodule
